// File: rtl/mux10_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux10_rr_arbiter
// Purpose  : Round-robin arbiter and select sequencer for a 10:1 data mux.
//            Grants one of ten requesters at a time and drives the mux select
//            with the granted index. Each grant lasts at most HOLD_MAX
//            consecutive cycles, so no requester can starve the others.
// Ports    : CLK   - clock; all state changes on the rising edge
//            RST   - synchronous, active-high reset
//            EN    - arbitration enable; low releases any grant and blocks
//                    new grants
//            REQ   - request vector; bit i requests mux input i
//            SL    - mux select; index of the current or last grant (0..9)
//            GNT   - one-hot grant; all zero while no grant is active
//            VALID - high while a grant is active (equals |GNT)
// Revision : 1.0 - initial release
// ============================================================================
module mux10_rr_arbiter #(
    parameter int HOLD_MAX = 8      // legal range 1..255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [9:0]  REQ,
    output logic [3:0]  SL,
    output logic [9:0]  GNT,
    output logic        VALID
);

    localparam logic [7:0] c_hold_max = 8'(HOLD_MAX);
    localparam logic [3:0] c_last_rst = 4'd9;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  sl_q, sl_d;
    logic [9:0]  gnt_q, gnt_d;
    logic        valid_q, valid_d;

    logic        w_release;
    logic [3:0]  w_winner;

    // First requester found when scanning last+1, last+2, ... wrapping at 10
    // and ending at last itself, so the previous winner has lowest priority
    // but still wins when it is the only requester.
    function automatic logic [3:0] f_winner(input logic [3:0] last,
                                            input logic [9:0] req);
        logic [3:0] w;
        logic       found;
        logic [4:0] idx;
        w     = last;
        found = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            idx = {1'b0, last} + 5'(k);
            if (idx >= 5'd10) begin
                idx = idx - 5'd10;
            end
            if (!found && req[idx[3:0]]) begin
                w     = idx[3:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // last_q already equals the releasing index when a grant ends, so the
    // same-edge re-arbitration simply scans from last_q.
    assign w_winner  = f_winner(last_q, REQ);
    assign w_release = (state_q == S_GRANT) &&
                       (!REQ[sl_q] || (cnt_q == c_hold_max) || !EN);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sl_d    = sl_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;

        if ((state_q == S_IDLE) || w_release) begin
            if (EN && (REQ != 10'd0)) begin
                // Load a fresh grant; back-to-back with no idle cycle.
                state_d = S_GRANT;
                last_d  = w_winner;
                cnt_d   = 8'd1;
                sl_d    = w_winner;
                gnt_d   = 10'b1 << w_winner;
                valid_d = 1'b1;
            end else begin
                // Nothing to grant: drop the grant, keep SL stable.
                state_d = S_IDLE;
                gnt_d   = 10'd0;
                valid_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            last_q  <= c_last_rst;
            cnt_q   <= 8'd0;
            sl_q    <= 4'd0;
            gnt_q   <= 10'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sl_q    <= sl_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign SL    = sl_q;
    assign GNT   = gnt_q;
    assign VALID = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux10_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux10_rr_arbiter
// Purpose  : Self-checking bench for mux10_rr_arbiter. Three instances with
//            HOLD_MAX = 8, 4 and 1 share the same inputs; each is compared
//            every cycle against a behavioural reference model, plus
//            directed checks for startup, rotation, timeout, drop,
//            wrap-around, EN and mid-grant reset, then a random phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux10_rr_arbiter;

    localparam int NDUT = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [9:0] REQ;

    logic [3:0] sl_o    [NDUT];
    logic [9:0] gnt_o   [NDUT];
    logic       valid_o [NDUT];

    int holds [NDUT] = '{8, 4, 1};

    // Reference model state, one set per instance.
    bit m_act  [NDUT];
    int m_sl   [NDUT];
    int m_last [NDUT];
    int m_cnt  [NDUT];

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mux10_rr_arbiter #(.HOLD_MAX(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
        .SL(sl_o[0]), .GNT(gnt_o[0]), .VALID(valid_o[0]));
    mux10_rr_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
        .SL(sl_o[1]), .GNT(gnt_o[1]), .VALID(valid_o[1]));
    mux10_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
        .SL(sl_o[2]), .GNT(gnt_o[2]), .VALID(valid_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec-level behaviour of one arbiter for one clock edge.
    task automatic model_edge(input int k, input bit rst, input bit en,
                              input logic [9:0] req);
        bit rel;
        int w;
        if (rst) begin
            m_act[k] = 0; m_sl[k] = 0; m_last[k] = 9; m_cnt[k] = 0;
        end else begin
            rel = m_act[k] && (!req[m_sl[k]] || m_cnt[k] == holds[k] || !en);
            if (!m_act[k] || rel) begin
                if (en && req != 0) begin
                    w = -1;
                    for (int j = 1; j <= 10; j++) begin
                        if (w < 0 && req[(m_last[k] + j) % 10])
                            w = (m_last[k] + j) % 10;
                    end
                    m_act[k] = 1; m_sl[k] = w; m_last[k] = w; m_cnt[k] = 1;
                end else begin
                    m_act[k] = 0;
                end
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    // Apply inputs, advance one edge, then compare all instances to the model.
    task automatic step(input bit rst, input bit en, input logic [9:0] req);
        RST = rst; EN = en; REQ = req;
        @(posedge CLK);
        for (int k = 0; k < NDUT; k++) model_edge(k, rst, en, req);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("valid%0d", k), 32'(valid_o[k]), 32'(m_act[k]));
            chk($sformatf("sl%0d", k), 32'(sl_o[k]), 32'(m_sl[k]));
            chk($sformatf("gnt%0d", k), 32'(gnt_o[k]),
                m_act[k] ? (32'd1 << m_sl[k]) : 32'd0);
        end
    endtask

    initial begin
        logic [9:0] rreq;
        bit         ren;
        bit         rrst;

        // Reset, startup and tie-break.
        step(1'b1, 1'b1, 10'h3FF);
        step(1'b1, 1'b1, 10'h3FF);
        chk("rst_gnt", 32'(gnt_o[0]), 32'h0);
        chk("rst_valid", 32'(valid_o[0]), 32'h0);
        chk("rst_sl", 32'(sl_o[0]), 32'h0);

        // Full rotation: HOLD_MAX=8 holds each index 8 cycles,
        // HOLD_MAX=1 rotates every cycle, VALID never drops.
        for (int c = 0; c < 88; c++) begin
            step(1'b0, 1'b1, 10'h3FF);
            if (c == 0) chk("first_gnt", 32'(gnt_o[0]), 32'h001);
            chk("rot8_sl", 32'(sl_o[0]), 32'((c / 8) % 10));
            chk("rot8_valid", 32'(valid_o[0]), 32'h1);
            chk("rot1_sl", 32'(sl_o[2]), 32'(c % 10));
        end

        // Single requester with timeout: grant is continuous.
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b1, 10'h080);
            chk("single_gnt4", 32'(gnt_o[1]), 32'h080);
            chk("single_gnt1", 32'(gnt_o[2]), 32'h080);
        end

        // Early drop: 3 granted from LAST=9, drops after 2 cycles -> 5.
        step(1'b1, 1'b1, 10'h000);
        step(1'b0, 1'b1, 10'h028);
        chk("drop_first", 32'(sl_o[0]), 32'd3);
        step(1'b0, 1'b1, 10'h028);
        step(1'b0, 1'b1, 10'h020);
        chk("drop_sl", 32'(sl_o[0]), 32'd5);
        chk("drop_gnt", 32'(gnt_o[0]), 32'h020);

        // Wrap-around: grant to 8 ended by drop, then 2 beats 8.
        step(1'b0, 1'b1, 10'h100);
        chk("wrap_pre", 32'(sl_o[0]), 32'd8);
        step(1'b0, 1'b1, 10'h000);
        chk("idle_sl_hold", 32'(sl_o[0]), 32'd8);
        step(1'b0, 1'b1, 10'h104);
        chk("wrap_sl", 32'(sl_o[0]), 32'd2);

        // EN low mid-grant: release, SL held.
        step(1'b0, 1'b0, 10'h104);
        chk("en_valid", 32'(valid_o[0]), 32'h0);
        chk("en_gnt", 32'(gnt_o[0]), 32'h0);
        chk("en_sl", 32'(sl_o[0]), 32'd2);
        step(1'b0, 1'b1, 10'h104);
        step(1'b0, 1'b1, 10'h3FF);

        // Reset mid-grant: abandon grant, pointer back to 9.
        step(1'b1, 1'b1, 10'h3FF);
        chk("mrst_valid", 32'(valid_o[0]), 32'h0);
        chk("mrst_sl", 32'(sl_o[0]), 32'h0);
        step(1'b0, 1'b1, 10'h3FF);
        chk("mrst_gnt", 32'(gnt_o[0]), 32'h001);

        // Random phase: requests persist for a few cycles so timeouts,
        // drops and back-to-back re-grants all occur.
        rreq = 10'h0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0)
                rreq = 10'($urandom) & 10'($urandom);
            ren  = ($urandom_range(0, 15) != 0);
            rrst = ($urandom_range(0, 79) == 0);
            step(rrst, ren, rreq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
